regfile_reader: RTL and testbench
=================================

# regfile_reader

Dual-port read side of the processor register file. It holds the register bank, which is built from falling-edge, enable-gated flops written by the writeback stage. It serves read requests from decode with a valid/ready handshake. Each read captures both operands on the rising edge and holds them in a two-entry skid buffer, so decode stalls never lose a read.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, register index width; the bank has 2**ADDR_W registers
- clk  in  1  clock; writes on the falling edge, reads and control on the rising edge
- clr  in  1  asynchronous, active-low reset
- we  in  1  write enable, sampled on the falling edge
- waddr  in  ADDR_W  write index; index 0 ignored
- wdata  in  DATA_W  write data
- req_valid  in  1  read request valid
- req_ready  out  1  block can accept a request
- rs1, rs2  in  ADDR_W  source indices
- rsp_valid  out  1  operand pair valid
- rsp_ready  in  1  consumer accepts the pair
- rd1, rd2  out  DATA_W  operand values
- reads_cnt  out  32  accepted-request count (REGFILE_READ_PERF_EN only)
- stall_cnt  out  32  backpressure cycle count (REGFILE_READ_PERF_EN only)

## Operation
- Bank: register r is loaded with wdata on the falling edge of clk when we=1 and waddr=r, r≠0. Register 0 always reads 0.
- Request accept: a request is accepted on the rising edge where req_valid && req_ready. The bank values at that instant are captured into the buffer as a snapshot.
- Snapshot semantics: later writes never alter a captured pair, including while the pair is stalled.
- Buffer FSM states, tracking entry count:
  - EMPTY: req_ready=1, rsp_valid=0.
  - ONE: req_ready=1, rsp_valid=1.
  - TWO: req_ready=0, rsp_valid=1.
- FSM transitions, with acc = accept and drn = rsp_valid && rsp_ready:
  - EMPTY → ONE on acc.
  - ONE → TWO on acc && !drn.
  - ONE → EMPTY on drn && !acc.
  - ONE stays ONE on acc && drn: the head is popped and the new pair becomes the head.
  - TWO → ONE on drn.
- Output order: rd1/rd2 always present the head entry. Pairs leave in acceptance order.
- Width rules: no arithmetic on data. Indices are unsigned; every value of ADDR_W bits is legal.

## Timing
- Read latency is 1 cycle: a request accepted at edge N gives rsp_valid=1 with its data after edge N.
- Write-to-read: a write on the falling edge at N−½ is visible to a read captured at rising edge N. No forwarding path is needed.
- A write and a read to the same index in the same high phase return the old value, since the write lands at the following falling edge.
- req_ready depends only on the registered state; it has no combinational path from rsp_ready.
- rsp_valid, rd1 and rd2 are registered outputs.
- Reset (clr=0, at any time, including mid-handshake or with a full buffer):
  - State goes to EMPTY; buffered pairs are discarded.
  - rsp_valid=0, rd1=rd2=0, req_ready=1.
  - All bank registers are 0.
  - reads_cnt=stall_cnt=0.
- After clr deasserts, the first accept is possible at the next rising edge.

## Configuration
- REGFILE_READ_PERF_EN
  - Defined: reads_cnt increments on each accept, and stall_cnt increments on each rising edge with rsp_valid && !rsp_ready. Both are 32-bit and wrap from 0xFFFFFFFF to 0.
  - Undefined: the counters and their ports are absent. All other behaviour is identical.

## Structure
- Shared package regfile_pkg holds:
  - DATA_W and ADDR_W defaults.
  - The buffer state enum {EMPTY, ONE, TWO}.
  - A packed struct for an operand pair (rd1, rd2).
- Sub-module regfile_bank:
  - Storage array of falling-edge, enable-gated flops with asynchronous clear.
  - Two combinational read ports.
  - Register 0 hardwired to 0.
- regfile_reader contains the FSM, the two-entry buffer and the optional counters.

## Test plan
- Reset then read: write r5=0x1234 on a falling edge, then request rs1=5, rs2=0 → one cycle later rsp_valid=1, rd1=0x1234, rd2=0.
- Write to r0: we=1, waddr=0, wdata=0xFFFFFFFF, then read rs1=0 → rd1=0.
- Backpressure: hold rsp_ready=0 and issue 3 requests for r1=1, r2=2, r3=3 → first two accepted, req_ready=0 afterwards. Release rsp_ready → pairs drain as 1 then 2, and the third request is then accepted.
- Snapshot under stall: read r7=0xA while stalled, then write r7=0xB → stalled rd1 stays 0xA; the next read returns 0xB.
- Simultaneous accept and drain in ONE with rsp_ready=1 and back-to-back requests → one pair per cycle, req_ready stays 1, order preserved.
- Reset mid-operation: pull clr low with TWO entries buffered → rsp_valid=0 immediately, all registers read 0 after release, and with REGFILE_READ_PERF_EN defined the counters read 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the register file read side: default widths,
// the skid buffer state encoding and the operand pair record.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    // Number of entries currently held in the two-entry skid buffer
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_state_t;

    // One captured read: both source operands at the default width
    typedef struct packed {
        logic [DATA_W_DEF-1:0] rd1;
        logic [DATA_W_DEF-1:0] rd2;
    } operand_pair_t;

endpackage

// File: rtl/regfile_bank.sv
// Register bank: falling-edge, enable-gated storage with two combinational
// read ports. Register 0 is never written and always reads as zero.
module regfile_bank
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2
);

    localparam int NREGS = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [NREGS];

    // Writeback lands on the falling edge so a read at the next rising edge sees it
    always_ff @(negedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    // Index 0 is forced to zero on the read side as well as never being written
    always_comb begin
        rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
        rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];
    end

endmodule

// File: rtl/regfile_reader.sv
// Read side of the register file: accepts decode requests with valid/ready,
// snapshots both operands into a two-entry skid buffer and presents the head.
// Optional performance counters are built when REGFILE_READ_PERF_EN is defined.
module regfile_reader
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2
`ifdef REGFILE_READ_PERF_EN
    ,
    output logic [31:0]       reads_cnt,
    output logic [31:0]       stall_cnt
`endif
);

    typedef struct packed {
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
    } pair_t;

    buf_state_t state, state_nxt;
    pair_t      head, second, snap;
    logic       acc, drn;

    regfile_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_bank (
        .clk    (clk),
        .clr    (clr),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .raddr1 (rs1),
        .raddr2 (rs2),
        .rdata1 (snap.rd1),
        .rdata2 (snap.rd2)
    );

    assign req_ready = (state != TWO);
    assign acc       = req_valid && req_ready;
    assign drn       = rsp_valid && rsp_ready;
    assign rd1       = head.rd1;
    assign rd2       = head.rd2;

    // Next buffer occupancy from accept and drain
    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   if (acc) state_nxt = ONE;
            ONE: begin
                if (acc && !drn)      state_nxt = TWO;
                else if (drn && !acc) state_nxt = EMPTY;
            end
            TWO:     if (drn) state_nxt = ONE;
            default: state_nxt = EMPTY;
        endcase
    end

    // Occupancy register and registered response valid
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state     <= EMPTY;
            rsp_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            rsp_valid <= (state_nxt != EMPTY);
        end
    end

    // Buffer entries: a new snapshot goes to the head if it is free (or being
    // popped this edge), otherwise behind it; a drain from TWO promotes the second
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            head   <= '0;
            second <= '0;
        end else begin
            if (acc && ((state == EMPTY) || ((state == ONE) && drn))) begin
                head <= snap;
            end else if ((state == TWO) && drn) begin
                head <= second;
            end
            if (acc && (state == ONE) && !drn) begin
                second <= snap;
            end
        end
    end

`ifdef REGFILE_READ_PERF_EN
    // Accepted reads and cycles where a valid pair waits on the consumer
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            reads_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (acc) reads_cnt <= reads_cnt + 32'd1;
            if (rsp_valid && !rsp_ready) stall_cnt <= stall_cnt + 32'd1;
        end
    end
`else
    // Without the performance option the block has no counters
`endif

endmodule

// File: tb/tb_regfile_reader.sv
// Self-checking bench for regfile_reader: directed scenarios followed by
// random traffic, compared against a queue-and-array reference model.
// Counter checks are compiled in when REGFILE_READ_PERF_EN is defined.
module tb_regfile_reader;
    import regfile_pkg::*;

    logic        clk;
    logic        clr;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rd1;
    logic [31:0] rd2;
`ifdef REGFILE_READ_PERF_EN
    logic [31:0] reads_cnt;
    logic [31:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0]   mregs [32];
    operand_pair_t mq [$];
    logic [31:0]   mreads;
    logic [31:0]   mstalls;

    regfile_reader #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk       (clk),
        .clr       (clr),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .rs1       (rs1),
        .rs2       (rs2),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rd1       (rd1),
        .rd2       (rd2)
`ifdef REGFILE_READ_PERF_EN
        ,
        .reads_cnt (reads_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    // Free-running clock, period 10
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expectVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        expectVal({tag, "_rsp_valid"}, {31'd0, rsp_valid}, {31'd0, mq.size() > 0});
        expectVal({tag, "_req_ready"}, {31'd0, req_ready}, {31'd0, mq.size() < 2});
        if (mq.size() > 0) begin
            expectVal({tag, "_rd1"}, rd1, mq[0].rd1);
            expectVal({tag, "_rd2"}, rd2, mq[0].rd2);
        end
`ifdef REGFILE_READ_PERF_EN
        expectVal({tag, "_reads_cnt"}, reads_cnt, mreads);
        expectVal({tag, "_stall_cnt"}, stall_cnt, mstalls);
`endif
    endtask

    // One clock cycle: drive inputs, model the falling-edge write and the
    // rising-edge handshake, then compare just after the rising edge
    task automatic applyStimulus(input string tag, input logic w, input logic [4:0] wa,
                                 input logic [31:0] wd, input logic rv, input logic [4:0] a1,
                                 input logic [4:0] a2, input logic rr);
        operand_pair_t p;
        logic          macc;
        logic          mdrn;
        we = w; waddr = wa; wdata = wd;
        req_valid = rv; rs1 = a1; rs2 = a2; rsp_ready = rr;
        @(negedge clk);
        if (w && (wa != 5'd0)) mregs[wa] = wd;
        @(posedge clk);
        macc = rv && (mq.size() < 2);
        mdrn = (mq.size() > 0) && rr;
        if ((mq.size() > 0) && !rr) mstalls++;
        if (mdrn) void'(mq.pop_front());
        if (macc) begin
            p.rd1 = mregs[a1];
            p.rd2 = mregs[a2];
            mq.push_back(p);
            mreads++;
        end
        #1;
        checkOutput(tag);
    endtask

    // Asynchronous reset pulse taken in the middle of the high phase
    task automatic doReset(input string tag);
        req_valid = 1'b0; we = 1'b0; rsp_ready = 1'b0;
        clr = 1'b0;
        #1;
        for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        mq.delete();
        mreads = 32'd0;
        mstalls = 32'd0;
        expectVal({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        expectVal({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
        expectVal({tag, "_rd1"}, rd1, 32'd0);
        expectVal({tag, "_rd2"}, rd2, 32'd0);
`ifdef REGFILE_READ_PERF_EN
        expectVal({tag, "_reads_cnt"}, reads_cnt, 32'd0);
        expectVal({tag, "_stall_cnt"}, stall_cnt, 32'd0);
`endif
        @(negedge clk);
        #2 clr = 1'b1;
    endtask

    initial begin
        we = 1'b0; waddr = '0; wdata = '0;
        req_valid = 1'b0; rs1 = '0; rs2 = '0; rsp_ready = 1'b0;
        clr = 1'b1;
        #1;
        doReset("reset");

        // Reset then read r5
        applyStimulus("wr_r5", 1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 5'd0, 1'b1);
        applyStimulus("rd_r5", 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd0, 1'b1);
        expectVal("rd_r5_val1", rd1, 32'h1234);
        expectVal("rd_r5_val2", rd2, 32'h0);

        // Writes to r0 are ignored
        applyStimulus("wr_r0", 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 5'd0, 1'b1);
        applyStimulus("rd_r0", 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd5, 1'b1);
        expectVal("rd_r0_val", rd1, 32'h0);
        applyStimulus("drain0", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b1);

        // Backpressure fills the buffer, then drains in order
        applyStimulus("wr_r1", 1'b1, 5'd1, 32'd1, 1'b0, 5'd0, 5'd0, 1'b1);
        applyStimulus("wr_r2", 1'b1, 5'd2, 32'd2, 1'b0, 5'd0, 5'd0, 1'b1);
        applyStimulus("wr_r3", 1'b1, 5'd3, 32'd3, 1'b0, 5'd0, 5'd0, 1'b1);
        applyStimulus("bp_req1", 1'b0, 5'd0, 32'd0, 1'b1, 5'd1, 5'd0, 1'b0);
        applyStimulus("bp_req2", 1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 5'd0, 1'b0);
        expectVal("bp_full_ready", {31'd0, req_ready}, 32'd0);
        applyStimulus("bp_req3", 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd0, 1'b0);
        expectVal("bp_hold_head", rd1, 32'd1);
        applyStimulus("bp_drain1", 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd0, 1'b1);
        expectVal("bp_second", rd1, 32'd2);
        applyStimulus("bp_drain2", 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd0, 1'b1);
        expectVal("bp_third", rd1, 32'd3);
        applyStimulus("bp_drain3", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b1);

        // Snapshot stays fixed while stalled
        applyStimulus("wr_r7a", 1'b1, 5'd7, 32'hA, 1'b0, 5'd0, 5'd0, 1'b1);
        applyStimulus("snap_rd", 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd7, 1'b0);
        applyStimulus("wr_r7b", 1'b1, 5'd7, 32'hB, 1'b0, 5'd0, 5'd0, 1'b0);
        expectVal("snap_hold", rd1, 32'hA);
        applyStimulus("snap_rd2", 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd0, 1'b0);
        expectVal("snap_hold2", rd1, 32'hA);
        applyStimulus("snap_pop", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b1);
        expectVal("snap_new", rd1, 32'hB);
        applyStimulus("snap_end", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b1);

        // Back-to-back requests with a ready consumer
        for (int i = 1; i < 7; i++) begin
            applyStimulus("b2b", 1'b0, 5'd0, 32'd0, 1'b1, 5'(i % 4), 5'(7), 1'b1);
            expectVal("b2b_ready", {31'd0, req_ready}, 32'd1);
        end
        applyStimulus("b2b_end", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b1);

        // Reset with a full buffer
        applyStimulus("rst_fill1", 1'b0, 5'd0, 32'd0, 1'b1, 5'd1, 5'd2, 1'b0);
        applyStimulus("rst_fill2", 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd7, 1'b0);
        expectVal("rst_full", {31'd0, req_ready}, 32'd0);
        doReset("mid_reset");
        for (int i = 0; i < 32; i++) begin
            applyStimulus("post_rst_rd", 1'b0, 5'd0, 32'd0, 1'b1, 5'(i), 5'(31 - i), 1'b1);
            expectVal("post_rst_zero", rd1 | rd2, 32'd0);
        end

        // Random traffic against the reference model
        for (int i = 0; i < 500; i++) begin
            applyStimulus("rand",
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom(),
                          1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)),
                          5'($urandom_range(0, 31)), 1'($urandom_range(0, 2) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
